// File: rtl/aes_decrypt_stream_if.sv
// Purpose : valid/ready bundle between a ciphertext source, the AES inverse cipher and its consumer.
// Latency : none (wires only).
// Backpressure: in_ready throttles the source; out_ready throttles the decryptor output.
// Ports   : in_valid/in_ready/in_data (ciphertext), all_keys (expanded key schedule, round 0 in MSBs),
//           out_valid/out_ready/out_data (plaintext). master = block driver/consumer, slave = decryptor.
interface aes_decrypt_stream_if #(
  parameter int NR = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic [127:0]            in_data;
  logic [(NR+1)*128-1:0]   all_keys;
  logic                    out_valid;
  logic                    out_ready;
  logic [127:0]            out_data;

  modport master (
    output in_valid, in_data, all_keys, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, all_keys, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_decrypt_stream.sv
// Purpose : iterative AES inverse cipher, one inverse round per clock, valid/ready on both sides.
// Latency : accept on edge k, out_valid high after edge k+NR; accept-to-accept >= NR+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is registered and depends on state only.
// Ports   : clk, rst_n (async active-low), bus (slave side of aes_decrypt_stream_if), busy (ROUND or DONE).
module aes_decrypt_stream #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_decrypt_stream_if.slave  bus,
  output logic                 busy
);

  // Key length and round count must describe the same AES variant.
  if (NR != NK + 6) begin : g_cfg_check
    $error("aes_decrypt_stream: NR must equal NK+6");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state;
  logic [127:0] st;
  logic [3:0]   ctr;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [127:0] out_data_q;
  logic [127:0] rk;
  logic [127:0] rnd;

  // GF(2^8) multiply, reduction polynomial 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse S-box built from its definition: undo the affine map, then take
  // the multiplicative inverse as y^254 (0 maps to 0 naturally).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] t;
    logic [7:0] acc;
    for (int i = 0; i < 8; i++)
      y[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8];
    y   = y ^ 8'h05;
    t   = y;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t   = gmul(t, t);
      acc = gmul(acc, t);
    end
    return acc;
  endfunction

  // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
  // Byte n sits at [127-8n -: 8], row n%4, column n/4.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    t = t ^ k;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        t[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        t[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        t[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        t[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return t;
  endfunction

  assign rk  = bus.all_keys[(NR - int'(ctr))*128 +: 128];
  assign rnd = inv_round(st, rk, ctr != 4'd0);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      st          <= '0;
      ctr         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            // Initial AddRoundKey with the last round key.
            st         <= bus.in_data ^ bus.all_keys[127:0];
            ctr        <= 4'(NR - 1);
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
            state      <= ROUND;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ROUND: begin
          if (ctr == 4'd0) begin
            out_data_q  <= rnd;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            st  <= rnd;
            ctr <= ctr - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_stream.sv
// Purpose : scoreboard bench for aes_decrypt_stream: FIPS vectors, backpressure, reset abort, encrypt round-trip.
// Latency : expects out_valid NR edges after each accept, accepts NR+2 apart when streaming.
// Backpressure: drives out_ready low for a window and checks the held result and in_ready.
module tb_aes_decrypt_stream;
  localparam int NR = 10;
  localparam int KW = (NR + 1) * 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  aes_decrypt_stream_if #(.NR(NR)) bus();

  aes_decrypt_stream #(.NK(4), .NR(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic [127:0] exp_q[$];
  int acc_q[$];
  int last_acc = 0;
  int prev_acc = 0;
  logic ov_prev = 1'b0;
  logic [7:0] sbox [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // ---------------- reference encrypt model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: brute-force inverse search followed by the affine map.
  function automatic void build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int i = 0; i < 8; i++)
        s[i] = s[i] ^ inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      sbox[x] = s;
    end
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [KW-1:0] expand(input logic [127:0] key);
    logic [31:0]   w [4*(NR+1)];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [KW-1:0] ks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    ks = '0;
    for (int i = 0; i < 4*(NR+1); i++) ks[KW-1-32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input bit mix);
    logic [127:0] t;
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
    o = t;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    return o ^ k;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [KW-1:0] ks);
    logic [127:0] s;
    s = pt ^ ks[NR*128 +: 128];
    for (int r = 1; r <= NR; r++) s = enc_round(s, ks[(NR-r)*128 +: 128], r != NR);
    return s;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      ov_prev = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        acc_q.push_back(cyc + 1);
        prev_acc = last_acc;
        last_acc = cyc + 1;
      end
      if (bus.out_valid && !ov_prev) begin
        if (acc_q.size() > 0) check("latency", 128'(cyc - acc_q.pop_front()), 128'(NR));
        else begin
          checks++;
          $display("FAIL latency: out_valid rose with no accepted block outstanding");
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() > 0) check("out_data", bus.out_data, exp_q.pop_front());
        else begin
          checks++;
          $display("FAIL unexpected_output: got %h required no output", bus.out_data);
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  // ---------------- stimulus ----------------
  // Keys/data are only changed once the previous block has produced out_valid
  // (or the DUT is idle), so all_keys stays stable for the block in flight.
  task automatic send(input logic [127:0] d, input logic [KW-1:0] k,
                      input logic [127:0] e, input bit expect_out);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.in_ready || bus.out_valid) && n < 300) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.all_keys = k;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    if (expect_out) exp_q.push_back(e);
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    if (n >= 300) begin
      checks++;
      $display("FAIL send_timeout: in_ready never seen, waited %0d cycles", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KW-1:0]  k2, k3, kr;
    logic [127:0]   ct2, pt2, ct3, pt3, key, pt;
    int n;

    ct2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pt2 = 128'h00112233445566778899aabbccddeeff;
    ct3 = 128'h3925841d02dc09fbdc118597196a0b32;
    pt3 = 128'h3243f6a8885a308d313198a2e0370734;

    build_sbox();
    k2 = expand(128'h000102030405060708090a0b0c0d0e0f);
    k3 = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.all_keys  = '0;
    bus.out_ready = 1'b1;

    // T1: reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_data", bus.out_data, 128'h0);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", 128'(bus.in_ready), 128'(1));
    check("release_busy", 128'(busy), 128'(0));

    // T2: FIPS-197 C.1 and T3: FIPS-197 B
    send(ct2, k2, pt2, 1'b1);
    drain();
    send(ct3, k3, pt3, 1'b1);
    drain();

    // T4: backpressure for six cycles after out_valid
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(ct2, k2, pt2, 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_valid_seen", 128'(bus.out_valid), 128'(1));
    for (int i = 0; i < 6; i++) begin
      check("bp_out_data", bus.out_data, pt2);
      check("bp_in_ready", 128'(bus.in_ready), 128'(0));
      check("bp_out_valid", 128'(bus.out_valid), 128'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 128'(bus.in_ready), 128'(1));
    check("bp_release_out_valid", 128'(bus.out_valid), 128'(0));
    drain();

    // T5: back-to-back with out_ready high
    send(ct3, k3, pt3, 1'b1);
    send(ct2, k2, pt2, 1'b1);
    check("b2b_accept_spacing", 128'(last_acc - prev_acc), 128'(NR + 2));
    drain();

    // T6: reset while ctr==5 discards the block
    send(ct2, k2, pt2, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("abort_no_valid", 128'(bus.out_valid), 128'(0));
    end
    send(ct2, k2, pt2, 1'b1);
    drain();

    // Round trip: reference encrypt, then decrypt in the DUT
    for (int i = 0; i < 100; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      kr  = expand(key);
      send(encrypt(pt, kr), kr, pt, 1'b1);
    end
    drain();
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
